// File: rtl/sc_displaytimer_downcounter.sv
// Countdown timer for the game-time display.
// Loads a start value, decrements it once per prescaled tick while running,
// holds it at zero on expiry and pulses timeout for one clock on expiry.
// Control inputs are active-low and sampled on the rising clock edge.
module sc_displaytimer_downcounter #(
  parameter int DOWNCOUNTER_DATAWIDTH       = 8,
  parameter int DOWNCOUNTER_PRESCALER_WIDTH = 26,
  parameter int DOWNCOUNTER_PRESCALER_MAX   = 49999999
) (
  input  logic                             SC_DISPLAYTIMER_DOWNCOUNTER_CLOCK_50,
  input  logic                             SC_DISPLAYTIMER_DOWNCOUNTER_RESET_InLow,
  input  logic                             SC_DISPLAYTIMER_DOWNCOUNTER_load_InLow,
  input  logic                             SC_DISPLAYTIMER_DOWNCOUNTER_start_InLow,
  input  logic                             SC_DISPLAYTIMER_DOWNCOUNTER_pause_InLow,
  input  logic [DOWNCOUNTER_DATAWIDTH-1:0] SC_DISPLAYTIMER_DOWNCOUNTER_data_InBUS,
  output logic [DOWNCOUNTER_DATAWIDTH-1:0] SC_DISPLAYTIMER_DOWNCOUNTER_data_OutBUS,
  output logic                             SC_DISPLAYTIMER_DOWNCOUNTER_running_Out,
  output logic                             SC_DISPLAYTIMER_DOWNCOUNTER_expired_Out,
  output logic                             SC_DISPLAYTIMER_DOWNCOUNTER_timeout_Out
);

  localparam int DW = DOWNCOUNTER_DATAWIDTH;
  localparam int PW = DOWNCOUNTER_PRESCALER_WIDTH;

  localparam logic [PW-1:0] PRESC_MAX  = PW'(DOWNCOUNTER_PRESCALER_MAX);
  localparam logic [PW-1:0] PRESC_ONE  = PW'(1);
  localparam logic [DW-1:0] COUNT_ZERO = '0;
  localparam logic [DW-1:0] COUNT_ONE  = DW'(1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_PAUSE   = 2'd2,
    ST_EXPIRED = 2'd3
  } state_e;

  // Short local names for the long port identifiers.
  logic clk;
  logic rst_n;
  logic load_n;
  logic start_n;
  logic pause_n;

  assign clk     = SC_DISPLAYTIMER_DOWNCOUNTER_CLOCK_50;
  assign rst_n   = SC_DISPLAYTIMER_DOWNCOUNTER_RESET_InLow;
  assign load_n  = SC_DISPLAYTIMER_DOWNCOUNTER_load_InLow;
  assign start_n = SC_DISPLAYTIMER_DOWNCOUNTER_start_InLow;
  assign pause_n = SC_DISPLAYTIMER_DOWNCOUNTER_pause_InLow;

  state_e          state_q,   state_d;
  logic [DW-1:0]   count_q,   count_d;
  logic [PW-1:0]   presc_q,   presc_d;
  logic            timeout_q, timeout_d;

  // Next-state logic: load > pause > prescaler terminal > start.
  always_comb begin
    // NOTE: every variable gets a default first so no path can infer a latch.
    state_d   = state_q;
    count_d   = count_q;
    presc_d   = presc_q;
    timeout_d = 1'b0;

    if (!load_n) begin
      count_d = SC_DISPLAYTIMER_DOWNCOUNTER_data_InBUS;
      presc_d = '0;
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          // Pause outranks start, so a held pause keeps the timer idle.
          if (pause_n && !start_n) begin
            if (count_q != COUNT_ZERO) begin
              state_d = ST_RUN;
              presc_d = '0;
            end else begin
              state_d   = ST_EXPIRED;
              timeout_d = 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (!pause_n) begin
            state_d = ST_PAUSE;
          end else if (presc_q == PRESC_MAX) begin
            presc_d = '0;
            count_d = count_q - COUNT_ONE;
            if (count_q == COUNT_ONE) begin
              state_d   = ST_EXPIRED;
              timeout_d = 1'b1;
            end
          end else begin
            presc_d = presc_q + PRESC_ONE;
          end
        end
        ST_PAUSE: begin
          // Prescaler keeps its partial-second progress across the pause.
          if (pause_n) begin
            state_d = ST_RUN;
          end
        end
        ST_EXPIRED: begin
          count_d = COUNT_ZERO;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      count_q   <= '0;
      presc_q   <= '0;
      timeout_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q   <= state_d;
      count_q   <= count_d;
      presc_q   <= presc_d;
      timeout_q <= timeout_d;
    end
  end

  assign SC_DISPLAYTIMER_DOWNCOUNTER_data_OutBUS = count_q;
  assign SC_DISPLAYTIMER_DOWNCOUNTER_running_Out = (state_q == ST_RUN);
  assign SC_DISPLAYTIMER_DOWNCOUNTER_expired_Out = (state_q == ST_EXPIRED);
  assign SC_DISPLAYTIMER_DOWNCOUNTER_timeout_Out = timeout_q;

endmodule

// File: tb/tb_sc_displaytimer_downcounter.sv
// Self-checking bench for sc_displaytimer_downcounter with a short prescaler.
// Each driven cycle pushes its expected outputs; a monitor pops and compares
// them shortly after the following rising edge.
module tb_sc_displaytimer_downcounter;

  localparam int DW  = 8;
  localparam int PW  = 4;
  localparam int MAX = 3;

  logic          clk;
  logic          rst_n;
  logic          load_n;
  logic          start_n;
  logic          pause_n;
  logic [DW-1:0] data_in;
  logic [DW-1:0] data_out;
  logic          running;
  logic          expired;
  logic          timeout;

  typedef struct {
    logic [DW-1:0] cnt;
    logic          run;
    logic          expd;
    logic          to;
    string         tag;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  sc_displaytimer_downcounter #(
    .DOWNCOUNTER_DATAWIDTH      (DW),
    .DOWNCOUNTER_PRESCALER_WIDTH(PW),
    .DOWNCOUNTER_PRESCALER_MAX  (MAX)
  ) dut (
    .SC_DISPLAYTIMER_DOWNCOUNTER_CLOCK_50   (clk),
    .SC_DISPLAYTIMER_DOWNCOUNTER_RESET_InLow(rst_n),
    .SC_DISPLAYTIMER_DOWNCOUNTER_load_InLow (load_n),
    .SC_DISPLAYTIMER_DOWNCOUNTER_start_InLow(start_n),
    .SC_DISPLAYTIMER_DOWNCOUNTER_pause_InLow(pause_n),
    .SC_DISPLAYTIMER_DOWNCOUNTER_data_InBUS (data_in),
    .SC_DISPLAYTIMER_DOWNCOUNTER_data_OutBUS(data_out),
    .SC_DISPLAYTIMER_DOWNCOUNTER_running_Out(running),
    .SC_DISPLAYTIMER_DOWNCOUNTER_expired_Out(expired),
    .SC_DISPLAYTIMER_DOWNCOUNTER_timeout_Out(timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Drive one cycle of inputs at the falling edge and record what the
  // outputs must read after the next rising edge.
  task automatic step(input logic ld, input logic st, input logic ps,
                      input logic [DW-1:0] d, input logic [DW-1:0] ec,
                      input logic er, input logic ee, input logic et,
                      input string tag);
    exp_t e;
    @(negedge clk);
    load_n  = ld;
    start_n = st;
    pause_n = ps;
    data_in = d;
    e.cnt  = ec;
    e.run  = er;
    e.expd = ee;
    e.to   = et;
    e.tag  = tag;
    exp_q.push_back(e);
  endtask

  // Monitor: compare DUT outputs against the oldest pending expectation.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check({e.tag, ".count"},   data_out, e.cnt);
      check({e.tag, ".running"}, running,  e.run);
      check({e.tag, ".expired"}, expired,  e.expd);
      check({e.tag, ".timeout"}, timeout,  e.to);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired got=%0d pending exp=0", exp_q.size());
    $fatal(1, "bench timeout");
  end

  initial begin
    rst_n   = 1'b0;
    load_n  = 1'b1;
    start_n = 1'b1;
    pause_n = 1'b1;
    data_in = 8'hA5;
    #1;
    check("por.count",   data_out, 0);
    check("por.running", running,  0);
    check("por.expired", expired,  0);
    check("por.timeout", timeout,  0);
    #1 rst_n = 1'b1;

    // Full countdown from 5: decrements after every fourth edge.
    step(0, 1, 1, 8'd5, 8'd5, 0, 0, 0, "cd.load");
    step(1, 0, 1, 8'd0, 8'd5, 1, 0, 0, "cd.start");
    for (int k = 1; k <= 20; k++) begin
      step(1, 1, 1, 8'd0, DW'(5 - k / 4), (k < 20), (k == 20), (k == 20),
           $sformatf("cd.e%0d", k));
    end
    // Expired hold: start and pause wiggled, count must stay 0, no timeout.
    for (int k = 1; k <= 50; k++) begin
      step(1, logic'(k % 2), logic'((k % 3) != 0), 8'd0, 8'd0, 0, 1, 0,
           $sformatf("exp.hold%0d", k));
    end

    // Pause from prescaler value 2 for ten clocks.
    step(0, 1, 1, 8'd3, 8'd3, 0, 0, 0, "pz.load");
    step(1, 0, 1, 8'd0, 8'd3, 1, 0, 0, "pz.start");
    step(1, 1, 1, 8'd0, 8'd3, 1, 0, 0, "pz.e1");
    step(1, 1, 1, 8'd0, 8'd3, 1, 0, 0, "pz.e2");
    for (int k = 0; k < 10; k++) begin
      step(1, 1, 0, 8'd0, 8'd3, 0, 0, 0, $sformatf("pz.hold%0d", k));
    end
    step(1, 1, 1, 8'd0, 8'd3, 1, 0, 0, "pz.resume");
    step(1, 1, 1, 8'd0, 8'd3, 1, 0, 0, "pz.r1");
    step(1, 1, 1, 8'd0, 8'd2, 1, 0, 0, "pz.r2dec");

    // Pause on the same edge the prescaler is terminal: no decrement.
    step(1, 1, 1, 8'd0, 8'd2, 1, 0, 0, "pt.p1");
    step(1, 1, 1, 8'd0, 8'd2, 1, 0, 0, "pt.p2");
    step(1, 1, 1, 8'd0, 8'd2, 1, 0, 0, "pt.p3");
    step(1, 1, 0, 8'd0, 8'd2, 0, 0, 0, "pt.pause");
    step(1, 1, 1, 8'd0, 8'd2, 1, 0, 0, "pt.resume");

    // Reload 9 while running at count 2 (prescaler terminal again).
    step(0, 0, 0, 8'd9, 8'd9, 0, 0, 0, "rl.load");
    step(1, 1, 1, 8'd0, 8'd9, 0, 0, 0, "rl.idle");

    // Load and start together: load only.
    step(0, 0, 1, 8'd7, 8'd7, 0, 0, 0, "ls.both");
    step(1, 1, 1, 8'd0, 8'd7, 0, 0, 0, "ls.idle");
    step(1, 0, 1, 8'd0, 8'd7, 1, 0, 0, "ls.start");
    step(1, 1, 1, 8'd0, 8'd7, 1, 0, 0, "ls.e1");
    step(1, 1, 1, 8'd0, 8'd7, 1, 0, 0, "ls.e2");

    // Asynchronous reset mid-cycle while running.
    @(posedge clk);
    #3;
    load_n  = 1'b0;
    start_n = 1'b0;
    pause_n = 1'b0;
    data_in = 8'h3C;
    rst_n   = 1'b0;
    #1;
    check("arst.count",   data_out, 0);
    check("arst.running", running,  0);
    check("arst.expired", expired,  0);
    check("arst.timeout", timeout,  0);
    @(negedge clk);
    load_n  = 1'b1;
    start_n = 1'b1;
    pause_n = 1'b1;
    rst_n   = 1'b1;
    step(1, 1, 1, 8'd0, 8'd0, 0, 0, 0, "arst.idle1");
    step(1, 1, 1, 8'd0, 8'd0, 0, 0, 0, "arst.idle2");

    // Zero start: immediate expiry, single timeout pulse, start ignored after.
    step(0, 1, 1, 8'd0, 8'd0, 0, 0, 0, "zs.load");
    step(1, 0, 1, 8'd0, 8'd0, 0, 1, 1, "zs.start");
    step(1, 0, 1, 8'd0, 8'd0, 0, 1, 0, "zs.restart");

    // Load all-ones out of EXPIRED and count down without wrap.
    step(0, 1, 1, 8'd255, 8'd255, 0, 0, 0, "ff.load");
    step(1, 0, 1, 8'd0,   8'd255, 1, 0, 0, "ff.start");
    for (int k = 1; k <= 4; k++) begin
      step(1, 1, 1, 8'd0, DW'(255 - k / 4), 1, 0, 0, $sformatf("ff.e%0d", k));
    end

    // Let the monitor drain the last expectations.
    repeat (3) @(posedge clk);
    #2;
    check("drain.pending", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
